// File: rtl/shared_reg_arbiter.sv
// Shared nbits-wide register with a four-requester round-robin write arbiter.
// Requesters that win arbitration may lock the register for multi-cycle bursts.
//   clk, rst      : clock and synchronous active-high reset
//   req, lock     : per-requester write request and lock (bit i = requester i)
//   wdata0..3     : write data for requesters 0..3
//   grant         : combinational one-hot (or zero) grant
//   q             : shared register value
//   upd, last_id  : registered write strobe and index of the most recent writer
module shared_reg_arbiter #(
  parameter int unsigned nbits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [nbits-1:0] wdata0,
  input  logic [nbits-1:0] wdata1,
  input  logic [nbits-1:0] wdata2,
  input  logic [nbits-1:0] wdata3,
  output logic [3:0]       grant,
  output logic [nbits-1:0] q,
  output logic             upd,
  output logic [1:0]       last_id
);

  logic [nbits-1:0] q_q, q_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             locked_q, locked_d;
  logic [1:0]       owner_q, owner_d;
  logic             upd_q, upd_d;
  logic [1:0]       last_id_q, last_id_d;

  logic [nbits-1:0] wdata_sel;
  logic             gvalid;
  logic [1:0]       gidx;
  logic [1:0]       idx;

  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    idx    = '0;
    if (!rst) begin
      if (locked_q && req[owner_q]) begin
        gvalid = 1'b1;
        gidx   = owner_q;
      end else begin
        // Owner dropping req falls through to round-robin from the held ptr.
        for (int unsigned i = 0; i < 4; i++) begin
          idx = ptr_q + 2'(i);
          if (!gvalid && req[idx]) begin
            gvalid = 1'b1;
            gidx   = idx;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gvalid) grant[gidx] = 1'b1;
  end

  always_comb begin
    case (gidx)
      2'd0:    wdata_sel = wdata0;
      2'd1:    wdata_sel = wdata1;
      2'd2:    wdata_sel = wdata2;
      default: wdata_sel = wdata3;
    endcase
  end

  always_comb begin
    q_d       = q_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    last_id_d = last_id_q;
    upd_d     = 1'b0;
    // Any cycle without a grant releases a held lock.
    locked_d  = 1'b0;
    if (gvalid) begin
      q_d       = wdata_sel;
      upd_d     = 1'b1;
      last_id_d = gidx;
      owner_d   = gidx;
      locked_d  = lock[gidx];
      if (!lock[gidx]) ptr_d = gidx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      ptr_q     <= '0;
      locked_q  <= 1'b0;
      owner_q   <= '0;
      upd_q     <= 1'b0;
      last_id_q <= '0;
    end else begin
      q_q       <= q_d;
      ptr_q     <= ptr_d;
      locked_q  <= locked_d;
      owner_q   <= owner_d;
      upd_q     <= upd_d;
      last_id_q <= last_id_d;
    end
  end

  assign q       = q_q;
  assign upd     = upd_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, lock;
  logic [7:0] wdata0, wdata1, wdata2, wdata3;
  logic [3:0] grant;
  logic [7:0] q;
  logic       upd;
  logic [1:0] last_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.nbits(8)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .grant(grant), .q(q), .upd(upd), .last_id(last_id)
  );

  // Inputs for one cycle; grant checked before the edge, q/upd/last_id after it.
  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic [7:0] q;
    logic       upd;
    logic [1:0] last;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic r, logic [3:0] rq, logic [3:0] lk,
                              logic [3:0] g, logic [7:0] eq, logic eu, logic [1:0] el);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.lock = lk;
    v.grant = g; v.q = eq; v.upd = eu; v.last = el;
    vecs.push_back(v);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    rst = v.rst; req = v.req; lock = v.lock;
    #1;
    chk({v.name, ".grant"}, 32'(grant), 32'(v.grant));
    chk({v.name, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
    @(posedge clk);
    #1;
    chk({v.name, ".q"}, 32'(q), 32'(v.q));
    chk({v.name, ".upd"}, 32'(upd), 32'(v.upd));
    chk({v.name, ".last_id"}, 32'(last_id), 32'(v.last));
  endtask

  initial begin
    wdata0 = 8'h10; wdata1 = 8'h11; wdata2 = 8'h12; wdata3 = 8'h13;
    rst = 1'b1; req = '0; lock = '0;

    //   name       rst  req      lock     grant    q      upd  last
    add("rst0",     1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 0, 2'd0);
    add("rst1",     1, 4'b1111, 4'b0000, 4'b0000, 8'h00, 0, 2'd0);
    add("rot0",     0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 1, 2'd0);
    add("rot1",     0, 4'b1111, 4'b0000, 4'b0010, 8'h11, 1, 2'd1);
    add("rot2",     0, 4'b1111, 4'b0000, 4'b0100, 8'h12, 1, 2'd2);
    add("rot3",     0, 4'b1111, 4'b0000, 4'b1000, 8'h13, 1, 2'd3);
    add("rot4",     0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 1, 2'd0);
    add("to3",      0, 4'b1000, 4'b0000, 4'b1000, 8'h13, 1, 2'd3);
    add("skip",     0, 4'b0110, 4'b0000, 4'b0010, 8'h11, 1, 2'd1);
    add("wrap",     0, 4'b0101, 4'b0000, 4'b0100, 8'h12, 1, 2'd2);
    add("idle",     0, 4'b0000, 4'b0000, 4'b0000, 8'h12, 0, 2'd2);
    add("lk_acq",   0, 4'b0010, 4'b0010, 4'b0010, 8'h11, 1, 2'd1);
    add("lk_b1",    0, 4'b1111, 4'b0010, 4'b0010, 8'h11, 1, 2'd1);
    add("lk_b2",    0, 4'b1111, 4'b0010, 4'b0010, 8'h11, 1, 2'd1);
    add("lk_rel",   0, 4'b1111, 4'b0000, 4'b0010, 8'h11, 1, 2'd1);
    add("lk_after", 0, 4'b1111, 4'b0000, 4'b0100, 8'h12, 1, 2'd2);
    add("nolk3",    0, 4'b1111, 4'b0111, 4'b1000, 8'h13, 1, 2'd3);
    add("nolk0",    0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 1, 2'd0);
    add("ab_pre",   0, 4'b0010, 4'b0000, 4'b0010, 8'h11, 1, 2'd1);
    add("ab_lk2",   0, 4'b0100, 4'b0100, 4'b0100, 8'h12, 1, 2'd2);
    add("ab_drop",  0, 4'b1001, 4'b0000, 4'b1000, 8'h13, 1, 2'd3);
    add("ab_clr",   0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 1, 2'd0);
    add("ml_lk3",   0, 4'b1000, 4'b1000, 4'b1000, 8'h13, 1, 2'd3);
    add("ml_rst",   1, 4'b1111, 4'b1000, 4'b0000, 8'h00, 0, 2'd0);
    add("ml_post",  0, 4'b1111, 4'b0000, 4'b0001, 8'h10, 1, 2'd0);

    foreach (vecs[i]) apply(vecs[i]);

    // Locked burst with changing data: ptr is 1, owner 2 writes fresh data each cycle.
    wdata2 = 8'hA5;
    rst = 1'b0; req = 4'b0100; lock = 4'b0100;
    #1 chk("burst_g0", 32'(grant), 32'(4'b0100));
    @(posedge clk); #1;
    chk("burst_q0", 32'(q), 32'h00A5);
    wdata2 = 8'h5A; req = 4'b1111;
    #1 chk("burst_g1", 32'(grant), 32'(4'b0100));
    @(posedge clk); #1;
    chk("burst_q1", 32'(q), 32'h005A);
    chk("burst_last", 32'(last_id), 32'd2);
    // Idle cycle while locked releases the lock; ptr still 1.
    req = 4'b0000; lock = 4'b0000;
    #1 chk("burst_idle_g", 32'(grant), 32'd0);
    @(posedge clk); #1;
    chk("burst_idle_upd", 32'(upd), 32'd0);
    chk("burst_idle_q", 32'(q), 32'h005A);
    req = 4'b1111;
    #1 chk("burst_resume_g", 32'(grant), 32'(4'b0010));
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
